// File: rtl/strobe_divider_bank.sv
// rtl/strobe_divider_bank.sv - multi-channel fractional strobe divider with double-buffered config
// Optional per-channel 16-bit tick counters are built when STROBE_TICK_COUNTER_EN is defined.
module strobe_divider_bank #(
  parameter int NUM_CH       = 2,
  parameter int DIV_W        = 12,
  parameter int FRAC_W       = 8,
  parameter int DEFAULT_DIV  = 1507,
  parameter int DEFAULT_FRAC = 0
) (
  input  logic                   IO_main_clk,
  input  logic                   IO_rst,
  input  logic [NUM_CH-1:0]      IO_en,
  input  logic                   IO_sync,
  input  logic                   IO_cfg_we,
  input  logic [2:0]             IO_cfg_ch,
  input  logic [DIV_W-1:0]       IO_cfg_div,
  input  logic [FRAC_W-1:0]      IO_cfg_frac,
  output logic [NUM_CH-1:0]      IO_tick,
  output logic [NUM_CH-1:0]      IO_cfg_pending,
  output logic [16*NUM_CH-1:0]   IO_tick_cnt
);

  localparam logic [3:0]        NUM_CH_L = 4'(NUM_CH);
  localparam logic [DIV_W-1:0]  DEF_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_FRAC);

  // cnt carries one extra bit so div + stretch never wraps at the maximum divisor
  logic [NUM_CH-1:0][DIV_W:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0][FRAC_W-1:0] acc_q, acc_d;
  logic [NUM_CH-1:0]             stretch_q, stretch_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  act_div_q, act_div_d, sh_div_q, sh_div_d;
  logic [NUM_CH-1:0][FRAC_W-1:0] act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
  logic [NUM_CH-1:0]             pend_q, pend_d;
  logic [NUM_CH-1:0]             tick_q, tick_d;
  logic                          cfg_hit;
  logic                          term;

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    stretch_d  = stretch_q;
    act_div_d  = act_div_q;
    act_frac_d = act_frac_q;
    sh_div_d   = sh_div_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    tick_d     = '0;
    term       = 1'b0;
    cfg_hit    = IO_cfg_we && ({1'b0, IO_cfg_ch} < NUM_CH_L);
    for (int c = 0; c < NUM_CH; c++) begin
      term = IO_en[c] &&
             (cnt_q[c] == ({1'b0, act_div_q[c]} + {{DIV_W{1'b0}}, stretch_q[c]}));
      if (IO_sync || !IO_en[c]) begin
        cnt_d[c]      = '0;
        acc_d[c]      = '0;
        stretch_d[c]  = 1'b0;
        act_div_d[c]  = sh_div_q[c];
        act_frac_d[c] = sh_frac_q[c];
        pend_d[c]     = 1'b0;
      end else if (term) begin
        cnt_d[c]  = '0;
        tick_d[c] = 1'b1;
        {stretch_d[c], acc_d[c]} = {1'b0, acc_q[c]} + {1'b0, act_frac_q[c]};
        if (pend_q[c]) begin
          act_div_d[c]  = sh_div_q[c];
          act_frac_d[c] = sh_frac_q[c];
          pend_d[c]     = 1'b0;
        end
      end else begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
      // a write landing on a load cycle wins the pending flag for the next boundary
      if (cfg_hit && (IO_cfg_ch == 3'(c))) begin
        sh_div_d[c]  = IO_cfg_div;
        sh_frac_d[c] = IO_cfg_frac;
        pend_d[c]    = 1'b1;
      end
    end
  end

  always_ff @(posedge IO_main_clk) begin
    if (IO_rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      stretch_q  <= '0;
      act_div_q  <= {NUM_CH{DEF_DIV}};
      sh_div_q   <= {NUM_CH{DEF_DIV}};
      act_frac_q <= {NUM_CH{DEF_FRAC}};
      sh_frac_q  <= {NUM_CH{DEF_FRAC}};
      pend_q     <= '0;
      tick_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      stretch_q  <= stretch_d;
      act_div_q  <= act_div_d;
      sh_div_q   <= sh_div_d;
      act_frac_q <= act_frac_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
    end
  end

  assign IO_tick        = tick_q;
  assign IO_cfg_pending = pend_q;

`ifdef STROBE_TICK_COUNTER_EN
  logic [NUM_CH-1:0][15:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (IO_sync)        tcnt_d[c] = '0;
      else if (tick_q[c]) tcnt_d[c] = tcnt_q[c] + 16'd1;
    end
  end

  always_ff @(posedge IO_main_clk) begin
    if (IO_rst) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
  end

  assign IO_tick_cnt = tcnt_q;
`else
  assign IO_tick_cnt = '0;
`endif

endmodule

// File: tb/tb_strobe_divider_bank.sv
// tb/tb_strobe_divider_bank.sv - scoreboard bench for strobe_divider_bank
module tb_strobe_divider_bank;

  localparam int NUM_CH = 2;

  logic               clk = 1'b0;
  logic               rst, sync, cfg_we;
  logic [NUM_CH-1:0]  en;
  logic [2:0]         cfg_ch;
  logic [11:0]        cfg_div;
  logic [7:0]         cfg_frac;
  logic [NUM_CH-1:0]  tick, pend;
  logic [16*NUM_CH-1:0] tick_cnt;

  strobe_divider_bank dut (
    .IO_main_clk   (clk),
    .IO_rst        (rst),
    .IO_en         (en),
    .IO_sync       (sync),
    .IO_cfg_we     (cfg_we),
    .IO_cfg_ch     (cfg_ch),
    .IO_cfg_div    (cfg_div),
    .IO_cfg_frac   (cfg_frac),
    .IO_tick       (tick),
    .IO_cfg_pending(pend),
    .IO_tick_cnt   (tick_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int exp_q [NUM_CH][$];
  bit [NUM_CH-1:0] mon_en = '0;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [11:0] dv, input logic [7:0] fr);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_frac = fr;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic do_sync(output int s);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    s = cyc;
  endtask

  task automatic drain(input int c);
    chk($sformatf("missing_ticks_ch%0d", c), exp_q[c].size(), 0);
    mon_en[c] = 1'b0;
    exp_q[c].delete();
  endtask

  initial begin
    int s, r, e, t;
    rst = 1'b1; sync = 1'b0; cfg_we = 1'b0; en = '1;
    cfg_ch = '0; cfg_div = '0; cfg_frac = '0;

    fork
      forever begin
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
          if (mon_en[c] && tick[c]) begin
            if (exp_q[c].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_tick_ch%0d at cyc %0d: got tick expected none", c, cyc);
            end else begin
              chk($sformatf("tick_time_ch%0d", c), cyc, exp_q[c].pop_front());
            end
          end
        end
      end
    join_none

    step(3);
    chk("reset_tick", tick, 0);
    chk("reset_pending", pend, 0);
    chk("reset_tick_cnt", tick_cnt, 0);
    rst = 1'b0;
    r = cyc;

    // defaults: period 1508
    exp_q[0].push_back(r + 1508);
    exp_q[0].push_back(r + 3016);
    exp_q[0].push_back(r + 4524);
    mon_en[0] = 1'b1;
    wait_until(r + 4524);
    drain(0);

    // fractional: div=3, frac=128 -> periods 4,4,5,4,5,...
    cfg_write(1, 12'd3, 8'd128);
    chk("pending_after_write_ch1", pend, 2'b10);
    do_sync(s);
    chk("pending_after_sync", pend, 2'b00);
    t = s;
    for (int k = 1; k <= 100; k++) begin
      t += (k == 1 || k % 2 == 0) ? 4 : 5;
      exp_q[1].push_back(t);
    end
    chk("frac_100_ticks_span", t - s, 449);
    mon_en[1] = 1'b1;
    wait_until(t);
    drain(1);

    // mid-period reconfiguration of channel 0
    cfg_write(0, 12'd9, 8'd0);
    do_sync(s);
    foreach (exp_q[0][i]) ;
    exp_q[0].push_back(s + 10);
    exp_q[0].push_back(s + 20);
    exp_q[0].push_back(s + 25);
    exp_q[0].push_back(s + 30);
    exp_q[0].push_back(s + 35);
    mon_en[0] = 1'b1;
    wait_until(s + 13);
    cfg_write(0, 12'd4, 8'd0);
    chk("pending_mid_period", pend, 2'b01);
    wait_until(s + 19);
    chk("pending_before_load", pend, 2'b01);
    wait_until(s + 20);
    chk("pending_after_load", pend, 2'b00);
    wait_until(s + 35);
    drain(0);

    // div=0, frac=0: tick every cycle; out-of-range write ignored
    cfg_write(0, 12'd0, 8'd0);
    do_sync(s);
    for (int k = 1; k <= 20; k++) exp_q[0].push_back(s + k);
    mon_en[0] = 1'b1;
    wait_until(s + 5);
    cfg_write(5, 12'd7, 8'd1);
    chk("pending_after_bad_ch_write", pend, 2'b00);
`ifndef STROBE_TICK_COUNTER_EN
    chk("tick_cnt_tied_zero", tick_cnt, 0);
`endif
    wait_until(s + 20);
    drain(0);

    // enable drop / raise, then sync on a terminal cycle
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    r = cyc;
    mon_en[0] = 1'b1;
    wait_until(r + 700);
    en = 2'b10;
    wait_until(r + 1508);
    chk("tick_while_disabled", tick[0], 0);
    wait_until(r + 1600);
    en = 2'b11;
    e = cyc;
    exp_q[0].push_back(e + 1508);
    exp_q[0].push_back(e + 3016 + 1508);
    wait_until(e + 3015);
    do_sync(s);
    chk("sync_edge_is_terminal", s, e + 3016);
    step(1);
    chk("no_tick_on_sync_terminal", tick[0], 0);
    wait_until(e + 4524);
    drain(0);

    // continuous ticks on channel 0, optionally checking the counter
    cfg_write(0, 12'd0, 8'd0);
    do_sync(s);
`ifdef STROBE_TICK_COUNTER_EN
    chk("tick_cnt_cleared_by_sync", tick_cnt[15:0], 0);
    wait_until(s + 10);
    chk("tick_cnt_ch0_count", tick_cnt[15:0], 9);
    wait_until(s + 65538);
    chk("tick_cnt_ch0_wrap", tick_cnt[15:0], 1);
`else
    wait_until(s + 3);
`endif
    chk("tick_high_before_reset", tick[0], 1);

    // reset mid-period discards pending configuration
    cfg_write(1, 12'd5, 8'd5);
    chk("pending_before_reset", pend[1], 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    r = cyc;
    chk("post_reset_tick", tick, 0);
    chk("post_reset_pending", pend, 0);
    chk("post_reset_tick_cnt", tick_cnt, 0);
    exp_q[1].push_back(r + 1508);
    mon_en[1] = 1'b1;
    wait_until(r + 1508);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
